// File: rtl/platform_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : platform_pkg
//  Description : Shared types and constants for the platform collision engine:
//                platform record, scan FSM states, game-state codes and the
//                initial platform layout table.
//  Revision    : 1.0 - initial release
// ============================================================================
package platform_pkg;

   localparam int PLATFORM_COUNT_DEFAULT = 8;

   // game_state encodings
   localparam logic [1:0] GS_IDLE = 2'd0;
   localparam logic [1:0] GS_PLAY = 2'd1;
   localparam logic [1:0] GS_OVER = 2'd2;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
   } platform_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_DONE = 2'd2
   } scan_state_t;

   // Starting layout; slots beyond the hand-placed eight get a spread-out
   // pseudo-pattern so larger configurations still start populated.
   function automatic platform_t initial_platform(input int idx);
      platform_t p;
      case (idx)
         0:       p = '{x: 11'd50,  y: 10'd650};
         1:       p = '{x: 11'd600, y: 10'd550};
         2:       p = '{x: 11'd200, y: 10'd450};
         3:       p = '{x: 11'd400, y: 10'd600};
         4:       p = '{x: 11'd650, y: 10'd350};
         5:       p = '{x: 11'd150, y: 10'd250};
         6:       p = '{x: 11'd500, y: 10'd150};
         7:       p = '{x: 11'd300, y: 10'd698};
         default: p = '{x: 11'(40 + (idx * 97) % 560), y: 10'((idx * 61) % 600)};
      endcase
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr16.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr16
//  Description : 16-bit Galois LFSR, taps 16,14,13,11 (mask 16'hB400).
//  Ports       : clk    - clock
//                load   - synchronous seed load (has priority over enable)
//                seed   - value loaded when load is high
//                enable - advance one step
//                value  - current register contents
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr16 (
   input  logic        clk,
   input  logic        load,
   input  logic [15:0] seed,
   input  logic        enable,
   output logic [15:0] value
);

   localparam logic [15:0] TAP_MASK = 16'hB400;

   always_ff @(posedge clk) begin
      if (load) begin
         value <= seed;
      end else if (enable) begin
         value <= {1'b0, value[15:1]} ^ (value[0] ? TAP_MASK : 16'h0000);
      end
   end

endmodule
`default_nettype wire

// File: rtl/platform_collider.sv
`default_nettype none
// ============================================================================
//  Module      : platform_collider
//  Description : Per-frame collision scan of the doodle's feet against every
//                platform slot (one slot per cycle), plus the world scroll
//                that moves platforms/ground down after a high landing and
//                respawns platforms falling off the bottom of the screen.
//  Ports       : clk, rst                 - clock, sync active-high reset
//                calculation_time         - one-cycle frame strobe
//                game_state               - 0 idle, 1 play, 2 game over
//                doodle_x/_y              - doodle left/top edge
//                doodle_fall_direction    - 1 while falling
//                collision                - landing found in last scan
//                move_collision           - that landing starts a scroll
//                ground[0]/ground[1]      - current / previous landing top
//                platform_x/platform_y    - platform layout for the renderer
//  Revision    : 1.0 - initial release
// ============================================================================
module platform_collider
   import platform_pkg::*;
#(
   parameter int PLATFORM_COUNT           = PLATFORM_COUNT_DEFAULT,
   parameter int PLATFORM_WIDTH           = 100,
   parameter int FOOT_TOLERANCE           = 20,
   parameter int DOODLE_WIDTH             = 80,
   parameter int DOODLE_HEIGHT            = 80,
   parameter int EARTH                    = 700,
   parameter int SHIFT_LINE               = 300,
   parameter int WORLD_SHIFT              = 5,
   parameter int GAME_VIEW_LEFT_BORDER_X  = 40,
   parameter int GAME_VIEW_RIGHT_BORDER_X = 760
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            calculation_time,
   input  logic [1:0]                      game_state,
   input  logic [10:0]                     doodle_x,
   input  logic [9:0]                      doodle_y,
   input  logic                            doodle_fall_direction,
   output logic                            collision,
   output logic                            move_collision,
   output logic [1:0][9:0]                 ground,
   output logic [PLATFORM_COUNT-1:0][10:0] platform_x,
   output logic [PLATFORM_COUNT-1:0][9:0]  platform_y
);

   localparam int              IDX_W        = (PLATFORM_COUNT > 1) ? $clog2(PLATFORM_COUNT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PLATFORM_COUNT - 1);
   localparam logic [11:0]     DOODLE_W_12  = 12'(DOODLE_WIDTH);
   localparam logic [11:0]     DOODLE_H_12  = 12'(DOODLE_HEIGHT);
   localparam logic [11:0]     PLAT_W_12    = 12'(PLATFORM_WIDTH);
   localparam logic [11:0]     FOOT_TOL_12  = 12'(FOOT_TOLERANCE);
   localparam logic [11:0]     EARTH_12     = 12'(EARTH);
   localparam logic [9:0]      EARTH_10     = 10'(EARTH);
   localparam logic [9:0]      SHIFT_LINE_10 = 10'(SHIFT_LINE);
   localparam logic [11:0]     SHIFT_12     = 12'(WORLD_SHIFT);
   localparam int              RESPAWN_SPAN = GAME_VIEW_RIGHT_BORDER_X - GAME_VIEW_LEFT_BORDER_X
                                              - PLATFORM_WIDTH;

   scan_state_t      state;
   logic [IDX_W-1:0] idx;
   logic [10:0]      lat_x;
   logic [9:0]       lat_y;
   logic             lat_fall;
   logic             found;
   logic [9:0]       hit_y;
   logic [3:0]       scroll_cnt;
   logic [15:0]      lfsr_value;

   // Scroll runs while the frame counter is non-zero; the consuming frame
   // loads 15, so 16 strobes shift in total (consuming one included).
   logic scroll_active;
   assign scroll_active = (scroll_cnt != 4'd0);

   lfsr16 u_lfsr (
      .clk    (clk),
      .load   (rst),
      .seed   (16'hACE1),
      .enable (1'b1),
      .value  (lfsr_value)
   );

   // ---------------------------------------------------------------- hit test
   logic [10:0] cur_x;
   logic [9:0]  cur_y;
   logic [11:0] doodle_right;
   logic [11:0] plat_right;
   logic [11:0] feet;
   logic [11:0] plat_low;
   logic        slot_hit;
   logic [9:0]  win_y;

   assign cur_x        = platform_x[idx];
   assign cur_y        = platform_y[idx];
   assign doodle_right = {1'b0, lat_x} + DOODLE_W_12;
   assign plat_right   = {1'b0, cur_x} + PLAT_W_12;
   assign feet         = {2'b0, lat_y} + DOODLE_H_12;
   assign plat_low     = {2'b0, cur_y} + FOOT_TOL_12;
   assign slot_hit     = lat_fall
                       && (doodle_right > {1'b0, cur_x})
                       && ({1'b0, lat_x} < plat_right)
                       && (feet >= {2'b0, cur_y})
                       && (feet < plat_low);
   // Earlier hit keeps priority over the slot being tested now.
   assign win_y        = found ? hit_y : cur_y;

   // ------------------------------------------------------- scroll / respawn
   logic [10:0]                     respawn_x;
   logic [PLATFORM_COUNT-1:0][10:0] shifted_x;
   logic [PLATFORM_COUNT-1:0][9:0]  shifted_y;
   logic [PLATFORM_COUNT-1:0][10:0] init_x;
   logic [PLATFORM_COUNT-1:0][9:0]  init_y;
   logic [1:0][9:0]                 shifted_ground;

   assign respawn_x = 11'(16'(GAME_VIEW_LEFT_BORDER_X) + lfsr_value % 16'(RESPAWN_SPAN));

   for (genvar i = 0; i < PLATFORM_COUNT; i++) begin : g_slot
      localparam platform_t INIT = initial_platform(i);
      logic [11:0] moved;
      assign moved        = {2'b0, platform_y[i]} + SHIFT_12;
      assign shifted_y[i] = (moved >= EARTH_12) ? 10'd0 : moved[9:0];
      assign shifted_x[i] = (moved >= EARTH_12) ? respawn_x : platform_x[i];
      assign init_x[i]    = INIT.x;
      assign init_y[i]    = INIT.y;
   end

   for (genvar g = 0; g < 2; g++) begin : g_ground
      logic [11:0] moved;
      assign moved             = {2'b0, ground[g]} + SHIFT_12;
      assign shifted_ground[g] = (moved > EARTH_12) ? EARTH_10 : moved[9:0];
   end

   // --------------------------------------------------------------- main FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_IDLE;
         idx            <= '0;
         lat_x          <= '0;
         lat_y          <= '0;
         lat_fall       <= 1'b0;
         found          <= 1'b0;
         hit_y          <= '0;
         collision      <= 1'b0;
         move_collision <= 1'b0;
         ground         <= {EARTH_10, EARTH_10};
         platform_x     <= init_x;
         platform_y     <= init_y;
         scroll_cnt     <= 4'd0;
      end else if (game_state == GS_IDLE) begin
         state          <= S_IDLE;
         idx            <= '0;
         found          <= 1'b0;
         collision      <= 1'b0;
         move_collision <= 1'b0;
         ground         <= {EARTH_10, EARTH_10};
         platform_x     <= init_x;
         platform_y     <= init_y;
         scroll_cnt     <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (calculation_time && (game_state == GS_PLAY)) begin
                  state          <= S_SCAN;
                  idx            <= '0;
                  found          <= 1'b0;
                  lat_x          <= doodle_x;
                  lat_y          <= doodle_y;
                  lat_fall       <= doodle_fall_direction;
                  collision      <= 1'b0;
                  move_collision <= 1'b0;
                  // A pending move_collision is consumed here and starts the scroll.
                  if (move_collision || scroll_active) begin
                     platform_x <= shifted_x;
                     platform_y <= shifted_y;
                     ground     <= shifted_ground;
                  end
                  if (move_collision) begin
                     scroll_cnt <= 4'd15;
                  end else if (scroll_active) begin
                     scroll_cnt <= scroll_cnt - 4'd1;
                  end
               end
            end
            S_SCAN: begin
               if (slot_hit && !found) begin
                  found <= 1'b1;
                  hit_y <= cur_y;
               end
               if (idx == LAST_IDX) begin
                  state <= S_DONE;
                  if (found || slot_hit) begin
                     collision      <= 1'b1;
                     ground[1]      <= ground[0];
                     ground[0]      <= win_y;
                     move_collision <= (win_y < SHIFT_LINE_10) && !scroll_active;
                  end
               end else begin
                  idx <= idx + IDX_W'(1);
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_platform_collider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_platform_collider
//  Description : Directed self-checking bench for platform_collider.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_platform_collider;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            calculation_time = 1'b0;
   logic [1:0]      game_state = 2'd1;
   logic [10:0]     doodle_x = '0;
   logic [9:0]      doodle_y = '0;
   logic            doodle_fall_direction = 1'b0;
   logic            collision;
   logic            move_collision;
   logic [1:0][9:0] ground;
   logic [7:0][10:0] platform_x;
   logic [7:0][9:0]  platform_y;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   platform_collider dut (
      .clk                   (clk),
      .rst                   (rst),
      .calculation_time      (calculation_time),
      .game_state            (game_state),
      .doodle_x              (doodle_x),
      .doodle_y              (doodle_y),
      .doodle_fall_direction (doodle_fall_direction),
      .collision             (collision),
      .move_collision        (move_collision),
      .ground                (ground),
      .platform_x            (platform_x),
      .platform_y            (platform_y)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One frame: strobe for a cycle, then wait past the scan latency.
   task automatic run_frame(input logic [10:0] x, input logic [9:0] y, input logic fall);
      @(posedge clk); #1;
      doodle_x              = x;
      doodle_y              = y;
      doodle_fall_direction = fall;
      calculation_time      = 1'b1;
      @(posedge clk); #1;
      calculation_time      = 1'b0;
      repeat (10) @(posedge clk);
      #1;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      check("rst_collision", collision, 0);
      check("rst_move", move_collision, 0);
      check("rst_ground0", ground[0], 700);
      check("rst_ground1", ground[1], 700);
      check("rst_py3", platform_y[3], 600);
      check("rst_px3", platform_x[3], 400);
      check("rst_py7", platform_y[7], 698);
      rst = 1'b0;

      // Hit while falling on slot 3
      run_frame(11'd380, 10'd525, 1'b1);
      check("fall_collision", collision, 1);
      check("fall_ground0", ground[0], 600);
      check("fall_ground1", ground[1], 700);
      check("fall_move", move_collision, 0);

      // Rising doodle: no hit, ground unchanged
      run_frame(11'd380, 10'd525, 1'b0);
      check("rise_collision", collision, 0);
      check("rise_ground0", ground[0], 600);
      check("rise_ground1", ground[1], 700);

      // feet = 620: just past the landing window
      run_frame(11'd380, 10'd540, 1'b1);
      check("feet620_collision", collision, 0);

      // feet = 619: last row of the window
      run_frame(11'd380, 10'd539, 1'b1);
      check("feet619_collision", collision, 1);
      check("feet619_ground1", ground[1], 600);

      // Horizontal edges
      run_frame(11'd320, 10'd525, 1'b1);
      check("x320_collision", collision, 0);
      run_frame(11'd321, 10'd525, 1'b1);
      check("x321_collision", collision, 1);

      // High landing on slot 5 (py=250) triggers a scroll
      run_frame(11'd150, 10'd180, 1'b1);
      check("high_collision", collision, 1);
      check("high_move", move_collision, 1);
      check("high_ground0", ground[0], 250);
      check("high_ground1", ground[1], 600);

      // Scroll frame 1: everything down by 5, slot 7 (698) respawns
      run_frame(11'd150, 10'd180, 1'b0);
      check("s1_py3", platform_y[3], 605);
      check("s1_py7_respawn", platform_y[7], 0);
      check("s1_px7_range", (platform_x[7] >= 40 && platform_x[7] < 660) ? 1 : 0, 1);
      check("s1_ground0", ground[0], 255);
      check("s1_ground1", ground[1], 605);
      check("s1_collision", collision, 0);
      check("s1_move", move_collision, 0);

      // Scroll frame 2: second high landing inside the window (slot 5 at 260)
      run_frame(11'd150, 10'd190, 1'b1);
      check("s2_collision", collision, 1);
      check("s2_move", move_collision, 0);
      check("s2_ground0", ground[0], 260);
      check("s2_ground1", ground[1], 260);

      // Scroll frames 3..16
      for (int k = 3; k <= 16; k++) begin
         run_frame(11'd150, 10'd190, 1'b0);
      end
      check("s16_py3", platform_y[3], 680);
      check("s16_py5", platform_y[5], 330);
      check("s16_py1", platform_y[1], 630);
      check("s16_py7", platform_y[7], 75);
      check("s16_ground0", ground[0], 330);
      check("s16_ground1", ground[1], 330);

      // Frame 17: scroll over, landing on slot 6 (now at 230) starts a new one
      run_frame(11'd500, 10'd155, 1'b1);
      check("f17_py3_still", platform_y[3], 680);
      check("f17_collision", collision, 1);
      check("f17_move", move_collision, 1);
      check("f17_ground0", ground[0], 230);
      check("f17_ground1", ground[1], 330);

      // Game over: strobe ignored, outputs and layout hold
      game_state = 2'd2;
      run_frame(11'd380, 10'd525, 1'b1);
      check("over_collision", collision, 1);
      check("over_move", move_collision, 1);
      check("over_py3", platform_y[3], 680);
      check("over_ground0", ground[0], 230);
      game_state = 2'd1;

      // Reset three cycles into a scan
      @(posedge clk); #1;
      doodle_x = 11'd380; doodle_y = 10'd525; doodle_fall_direction = 1'b1;
      calculation_time = 1'b1;
      @(posedge clk); #1;
      calculation_time = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("midrst_collision", collision, 0);
      check("midrst_move", move_collision, 0);
      check("midrst_ground0", ground[0], 700);
      check("midrst_ground1", ground[1], 700);
      check("midrst_py3", platform_y[3], 600);
      check("midrst_py7", platform_y[7], 698);
      rst = 1'b0;
      run_frame(11'd380, 10'd525, 1'b1);
      check("postrst_collision", collision, 1);
      check("postrst_ground0", ground[0], 600);
      check("postrst_move", move_collision, 0);

      // Idle game state reloads layout and ground
      game_state = 2'd0;
      repeat (2) @(posedge clk);
      #1;
      check("idle_ground0", ground[0], 700);
      check("idle_collision", collision, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/platform_collider.md
# platform_collider

Per-frame collision and world-scroll engine driving the doodle positioning logic. Holds the platform layout, scans every platform against the doodle's feet once per frame, and presents `collision`, `ground` and `move_collision` to the doodle block, stable at its next `calculation_time`. When a landing happens above the scroll line, it also scrolls the platforms down and respawns platforms that leave the screen.

## Interface
Parameters:
- `PLATFORM_COUNT`, 8: number of platform slots; the scan takes one slot per cycle.
- `PLATFORM_WIDTH`, 100: platform width in px.
- `FOOT_TOLERANCE`, 20: depth in px of the landing window, measured below a platform top.
- `DOODLE_WIDTH`, 80 / `DOODLE_HEIGHT`, 80: sprite size in px.
- `EARTH`, 700: floor y; also the initial ground.
- `SHIFT_LINE`, 300: a landing on a top with y < SHIFT_LINE triggers a scroll.
- `WORLD_SHIFT`, 5: px per frame that platforms and ground move down while scrolling.
- `GAME_VIEW_LEFT_BORDER_X`, `GAME_VIEW_RIGHT_BORDER_X`: horizontal range used for respawned x.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `calculation_time`, in, 1: one-cycle frame strobe.
- `game_state`, in, 2: 0 = idle, 1 = play, 2 = game over.
- `doodle_x`, in, 11: doodle left edge.
- `doodle_y`, in, 10: doodle top edge.
- `doodle_fall_direction`, in, 1: 1 = falling.
- `collision`, out, 1: a landing was detected in the last scan.
- `move_collision`, out, 1: that landing starts a scroll.
- `ground`, out, [1:0][9:0]: ground[0] = current landing top, ground[1] = previous.
- `platform_x`, out, [PLATFORM_COUNT-1:0][10:0]: platform left edges, for the renderer.
- `platform_y`, out, [PLATFORM_COUNT-1:0][9:0]: platform tops, for the renderer.

## Operation
- FSM states: IDLE, SCAN, DONE.
- IDLE → SCAN on `calculation_time` when game_state==1.
  - Latch doodle_x, doodle_y and fall_direction.
  - Clear `collision` and `move_collision`.
  - Apply the scroll step if it is active.
- In SCAN, slot i is tested at scan cycle i. The slot hits if all of the following hold:
  - fall_direction==1;
  - doodle_x + DOODLE_WIDTH > px[i] and doodle_x < px[i] + PLATFORM_WIDTH;
  - feet = doodle_y + DOODLE_HEIGHT satisfies py[i] ≤ feet < py[i] + FOOT_TOLERANCE.
- The lowest-index hit wins; later hits are ignored. Do the arithmetic in 12 bits, unsigned, so nothing wraps.
- After slot PLATFORM_COUNT−1 the FSM goes to DONE. On a hit:
  - `collision`=1;
  - ground[1] ← ground[0];
  - ground[0] ← py[hit];
  - `move_collision` = (py[hit] < SHIFT_LINE) and no scroll is active.
- DONE → IDLE after one cycle. The outputs hold until the next `calculation_time`.
- Scroll. On the frame that consumes `move_collision`=1, load a 4-bit frame counter with 15. On each of the next 16 `calculation_time` strobes:
  - every py += WORLD_SHIFT;
  - ground[0] += WORLD_SHIFT and ground[1] += WORLD_SHIFT, saturating at EARTH;
  - the counter decrements.
  This matches the doodle's own 16-frame shift.
- Respawn. A slot whose py ≥ EARTH after a shift gets py ← 0 and px ← GAME_VIEW_LEFT_BORDER_X + (lfsr mod (RIGHT − LEFT − PLATFORM_WIDTH)). The LFSR advances every clock.
- game_state==2: no scan and no scroll; outputs hold. game_state==0: the layout is reloaded from the package table and ground resets.

## Timing
- Reset values:
  - collision=0, move_collision=0;
  - ground={EARTH, EARTH};
  - platform arrays = package initial layout;
  - FSM=IDLE, scroll counter=0;
  - LFSR seed = 16'hACE1.
- Latency: results are valid PLATFORM_COUNT+2 cycles after `calculation_time`. Strobe spacing ≥ PLATFORM_COUNT+3 is required; a strobe that arrives during SCAN is ignored.
- The doodle samples on the strobe cycle, so it sees the previous frame's result. Clearing on the strobe edge is therefore safe.
- `rst` mid-scan aborts the scan and returns every register to its reset value on the next edge.
- A hit with a scroll active gives collision=1 and move_collision=0; the scroll is not restarted.
- A landing exactly at feet==py counts as a hit; feet==py+FOOT_TOLERANCE does not.

## Structure
- Package `platform_pkg` holds:
  - a `platform_t` struct {x[10:0], y[9:0]};
  - a PLATFORM_COUNT default;
  - the initial layout table;
  - the FSM state enum.
- Sub-module `lfsr16`: 16-bit Galois LFSR, taps 16,14,13,11, with an enable input and a synchronous seed load.

## Test plan
- Hit while falling:
  - Stimulus: slot 3 at (400,600); doodle (380,525), falling; strobe.
  - Response: after 10 cycles collision=1, ground[0]=600, move_collision=0.
- Rising doodle:
  - Stimulus: same geometry, fall_direction=0.
  - Response: collision=0, ground unchanged.
- Tolerance edges, using the hit-while-falling geometry:
  - feet=620 → no hit;
  - feet=619 → hit;
  - horizontal edge doodle_x=320 → no hit (320+80=400, not > 400);
  - doodle_x=321 → hit.
- Scroll trigger:
  - Stimulus: landing on py=250.
  - Response: move_collision=1. Over the next 16 strobes every py grows by 80 total, ground[0] goes 250→330, and a second high landing inside the window gives move_collision=0.
- Respawn:
  - Stimulus: slot at py=698 during a scroll.
  - Response: py becomes 0 and px lies within [LEFT, RIGHT−100).
- Reset mid-scan:
  - Stimulus: assert rst 3 cycles after the strobe.
  - Response: all outputs at reset values on the next cycle; the next strobe scans normally.
